// File: rtl/client_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module   : client_traffic_gen
// Purpose  : Burst write/readback traffic generator with LFSR gaps and
//            ack-timeout retry for one bus-arbiter client.
// Revision : 1.0 - initial release
// ============================================================================
module client_traffic_gen #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int BURST_LEN   = 4,
  parameter int GAP_WIDTH   = 3,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  ack,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rq,
  output logic                  wr_ni,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  mismatch,
  output logic                  timeout,
  output logic [7:0]            err_cnt
);

  localparam int c_BEAT_W = $clog2(BURST_LEN + 1);
  localparam int c_WAIT_W = $clog2(ACK_TIMEOUT);

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_GAP   = 3'd1;
  localparam logic [2:0] c_ST_WRITE = 3'd2;
  localparam logic [2:0] c_ST_READ  = 3'd3;
  localparam logic [2:0] c_ST_RETRY = 3'd4;

  logic [2:0]            r_state;
  logic [15:0]           r_lfsr;
  logic [GAP_WIDTH-1:0]  r_gap_cnt;
  logic [c_BEAT_W-1:0]   r_beat;
  logic                  r_phase;
  logic [ADDR_WIDTH-1:0] r_base_addr;
  logic [DATA_WIDTH-1:0] r_base_data;
  logic [c_WAIT_W-1:0]   r_wait_cnt;

  logic                  w_fb;
  logic [15:0]           w_lfsr_next;
  logic [c_BEAT_W-1:0]   w_beat_next;
  logic                  w_last;
  logic [ADDR_WIDTH-1:0] w_beat_addr;
  logic [DATA_WIDTH-1:0] w_beat_data;
  logic                  w_ack;

  // Fibonacci taps 16,14,13,11; the nonzero seed keeps it off the all-zero lock-up state
  assign w_fb        = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_lfsr_next = {r_lfsr[14:0], w_fb};
  assign w_beat_next = r_beat + c_BEAT_W'(1);
  assign w_last      = (w_beat_next == c_BEAT_W'(BURST_LEN));
  assign w_beat_addr = r_base_addr + ADDR_WIDTH'(r_beat);
  assign w_beat_data = r_base_data + DATA_WIDTH'(r_beat);
  assign w_ack       = rq & ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= c_ST_IDLE;
      r_lfsr      <= 16'hACE1;
      r_gap_cnt   <= '0;
      r_beat      <= '0;
      r_phase     <= 1'b0;
      r_base_addr <= '0;
      r_base_data <= '0;
      r_wait_cnt  <= '0;
      rq          <= 1'b0;
      wr_ni       <= 1'b0;
      addr        <= '0;
      wdata       <= '0;
      mismatch    <= 1'b0;
      timeout     <= 1'b0;
      err_cnt     <= 8'd0;
    end else begin
      mismatch <= 1'b0;
      timeout  <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (en) begin
            r_state   <= c_ST_GAP;
            r_gap_cnt <= r_lfsr[GAP_WIDTH-1:0];
            r_lfsr    <= w_lfsr_next;
          end
        end
        c_ST_GAP: begin
          if (r_gap_cnt == '0) begin
            r_state    <= r_phase ? c_ST_READ : c_ST_WRITE;
            rq         <= 1'b1;
            wr_ni      <= r_phase;
            addr       <= w_beat_addr;
            r_wait_cnt <= '0;
            if (!r_phase) begin
              wdata <= w_beat_data;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt - GAP_WIDTH'(1);
          end
        end
        c_ST_WRITE, c_ST_READ: begin
          if (w_ack) begin
            rq <= 1'b0;
            if (r_phase && (rdata != w_beat_data)) begin
              mismatch <= 1'b1;
              if (err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
              end
            end
            if (w_last) begin
              r_beat  <= '0;
              r_phase <= ~r_phase;
              if (r_phase) begin
                r_base_addr <= r_base_addr + ADDR_WIDTH'(BURST_LEN);
                r_base_data <= r_base_data + DATA_WIDTH'(BURST_LEN + 1);
              end
            end else begin
              r_beat <= w_beat_next;
            end
            // en only matters once the readback half of a burst has finished
            if (w_last && r_phase && !en) begin
              r_state <= c_ST_IDLE;
            end else begin
              r_state   <= c_ST_GAP;
              r_gap_cnt <= r_lfsr[GAP_WIDTH-1:0];
              r_lfsr    <= w_lfsr_next;
            end
          end else if (r_wait_cnt == c_WAIT_W'(ACK_TIMEOUT - 1)) begin
            timeout <= 1'b1;
            rq      <= 1'b0;
            r_state <= c_ST_RETRY;
          end else begin
            r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
          end
        end
        c_ST_RETRY: begin
          r_state    <= r_phase ? c_ST_READ : c_ST_WRITE;
          rq         <= 1'b1;
          r_wait_cnt <= '0;
        end
        default: begin
          r_state <= c_ST_IDLE;
          rq      <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_client_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_client_traffic_gen
// Purpose  : Directed, table-driven self-checking bench for client_traffic_gen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_client_traffic_gen;

  logic       clk;
  logic       rst;
  logic       en;
  logic       ack;
  logic [7:0] rdata;
  logic       rq;
  logic       wr_ni;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       mismatch;
  logic       timeout;
  logic [7:0] err_cnt;

  logic       ack_en;
  logic       bad;
  logic [7:0] mem [256];

  int checks;
  int errors;
  int to_cnt;
  int mis_cnt;

  typedef struct {
    logic       en;
    logic       bad;
    logic       exp_wr_ni;
    logic [7:0] exp_addr;
    logic [7:0] exp_wdata;
    logic       exp_mis;
    logic       idle_after;
  } vec_t;

  vec_t tbl [16];

  client_traffic_gen dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .ack      (ack),
    .rdata    (rdata),
    .rq       (rq),
    .wr_ni    (wr_ni),
    .addr     (addr),
    .wdata    (wdata),
    .mismatch (mismatch),
    .timeout  (timeout),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  // Arbiter stand-in: grants in the request cycle, memory echoes prior writes
  assign ack   = rq & ack_en;
  assign rdata = bad ? 8'hFF : mem[addr];

  always @(posedge clk) begin
    if (rq && ack && !wr_ni) mem[addr] <= wdata;
  end

  always @(negedge clk) begin
    if (timeout)  to_cnt  = to_cnt + 1;
    if (mismatch) mis_cnt = mis_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_txn(output logic ok);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (rq && ack) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL wait_txn: no acknowledged request within 200 cycles");
    end
  endtask

  task automatic wait_rq(output logic ok);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (rq) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL wait_rq: rq never rose within 200 cycles");
    end
  endtask

  task automatic set_vec(input int i, input logic e, input logic b, input logic w,
                         input logic [7:0] a, input logic [7:0] d, input logic m,
                         input logic idl);
    tbl[i].en         = e;
    tbl[i].bad        = b;
    tbl[i].exp_wr_ni  = w;
    tbl[i].exp_addr   = a;
    tbl[i].exp_wdata  = d;
    tbl[i].exp_mis    = m;
    tbl[i].idle_after = idl;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    logic saw_rq;
    int   n;

    // en, bad, wr_ni, addr, wdata, mismatch, idle_after
    set_vec( 0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    set_vec( 1, 1'b0, 1'b0, 1'b0, 8'd1, 8'd1, 1'b0, 1'b0);
    set_vec( 2, 1'b0, 1'b0, 1'b0, 8'd2, 8'd2, 1'b0, 1'b0);
    set_vec( 3, 1'b0, 1'b0, 1'b0, 8'd3, 8'd3, 1'b0, 1'b0);
    set_vec( 4, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 1'b0, 1'b0);
    set_vec( 5, 1'b0, 1'b0, 1'b1, 8'd1, 8'd0, 1'b0, 1'b0);
    set_vec( 6, 1'b0, 1'b1, 1'b1, 8'd2, 8'd0, 1'b1, 1'b0);
    set_vec( 7, 1'b0, 1'b0, 1'b1, 8'd3, 8'd0, 1'b0, 1'b1);
    set_vec( 8, 1'b1, 1'b0, 1'b0, 8'd4, 8'd5, 1'b0, 1'b0);
    set_vec( 9, 1'b1, 1'b0, 1'b0, 8'd5, 8'd6, 1'b0, 1'b0);
    set_vec(10, 1'b1, 1'b0, 1'b0, 8'd6, 8'd7, 1'b0, 1'b0);
    set_vec(11, 1'b1, 1'b0, 1'b0, 8'd7, 8'd8, 1'b0, 1'b0);
    set_vec(12, 1'b1, 1'b0, 1'b1, 8'd4, 8'd0, 1'b0, 1'b0);
    set_vec(13, 1'b1, 1'b0, 1'b1, 8'd5, 8'd0, 1'b0, 1'b0);
    set_vec(14, 1'b1, 1'b0, 1'b1, 8'd6, 8'd0, 1'b0, 1'b0);
    set_vec(15, 1'b1, 1'b0, 1'b1, 8'd7, 8'd0, 1'b0, 1'b0);

    checks = 0; errors = 0; to_cnt = 0; mis_cnt = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    clk = 1'b0; rst = 1'b1; en = 1'b0; ack_en = 1'b1; bad = 1'b0;

    repeat (2) @(negedge clk);
    check("reset_rq", rq, 1'b0);
    check("reset_wr_ni", wr_ni, 1'b0);
    check("reset_addr", addr, 8'd0);
    check("reset_wdata", wdata, 8'd0);
    check("reset_mismatch", mismatch, 1'b0);
    check("reset_timeout", timeout, 1'b0);
    check("reset_err_cnt", err_cnt, 8'd0);
    rst = 1'b0;

    // Two bursts: en dropped during beat 1, corrupted read at addr 2
    for (int i = 0; i < 16; i++) begin
      en  = tbl[i].en;
      bad = tbl[i].bad;
      wait_txn(ok);
      if (ok) begin
        check($sformatf("vec%0d_wr_ni", i), wr_ni, tbl[i].exp_wr_ni);
        check($sformatf("vec%0d_addr", i), addr, tbl[i].exp_addr);
        if (!tbl[i].exp_wr_ni) begin
          check($sformatf("vec%0d_wdata", i), wdata, tbl[i].exp_wdata);
        end else begin
          @(negedge clk);
          check($sformatf("vec%0d_mismatch", i), mismatch, tbl[i].exp_mis);
        end
      end
      if (tbl[i].idle_after) begin
        saw_rq = 1'b0;
        repeat (30) begin
          @(negedge clk);
          if (rq) saw_rq = 1'b1;
        end
        check($sformatf("vec%0d_idle_rq", i), saw_rq, 1'b0);
      end
    end
    check("err_cnt_after_bursts", err_cnt, 8'd1);

    // Third burst: corrupt reads, then reset while a read is pending
    bad = 1'b1;
    ok  = 1'b0;
    for (int k = 0; k < 6; k++) begin
      wait_txn(ok);
      if (!ok || wr_ni) break;
    end
    if (ok) begin
      check("burst3_first_read_addr", addr, 8'd8);
      @(negedge clk);
      check("burst3_mismatch", mismatch, 1'b1);
      check("burst3_err_cnt", err_cnt, 8'd2);
    end
    wait_rq(ok);
    check("rq_before_reset", rq, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_rq", rq, 1'b0);
    check("async_rst_mismatch", mismatch, 1'b0);
    check("async_rst_timeout", timeout, 1'b0);
    check("async_rst_err_cnt", err_cnt, 8'd0);
    check("async_rst_addr", addr, 8'd0);
    ack_en = 1'b0;
    bad    = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Restart latency: seeded LFSR gives a 2-cycle first gap
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n++;
      if (rq) break;
    end
    check("restart_latency", n, 3);
    check("restart_addr", addr, 8'd0);
    check("restart_wdata", wdata, 8'd0);

    // Withheld ack: timeout after 16 request cycles, 1-cycle drop, re-request
    n = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (timeout) break;
      if (rq) n++;
    end
    check("timeout_pulse", timeout, 1'b1);
    check("timeout_rq_high_cycles", n, 16);
    check("retry_rq_low", rq, 1'b0);
    @(negedge clk);
    check("retry_rq", rq, 1'b1);
    check("retry_timeout_cleared", timeout, 1'b0);
    check("retry_wr_ni", wr_ni, 1'b0);
    check("retry_addr", addr, 8'd0);
    check("retry_wdata", wdata, 8'd0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 ack_en = 1'b1;
    wait_txn(ok);
    check("retry_ack_addr", addr, 8'd0);
    check("retry_ack_wdata", wdata, 8'd0);

    // Ack arriving on the last allowed cycle beats the timeout
    @(posedge clk);
    #1 ack_en = 1'b0;
    wait_rq(ok);
    check("late_ack_addr", addr, 8'd1);
    n = 1;
    for (int k = 0; k < 30; k++) begin
      if (n == 16 || !rq) break;
      @(negedge clk);
      if (rq) n++;
    end
    check("late_ack_cycle", n, 16);
    ack_en = 1'b1;
    @(negedge clk);
    check("late_ack_no_timeout", timeout, 1'b0);
    check("late_ack_rq_dropped", rq, 1'b0);
    wait_txn(ok);
    check("late_ack_next_addr", addr, 8'd2);
    check("late_ack_next_wdata", wdata, 8'd2);

    repeat (3) @(negedge clk);
    check("total_timeout_pulses", to_cnt, 1);
    check("total_mismatch_pulses", mis_cnt, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
